// File: rtl/btn_sw_conditioner_if.sv
// Board-input conditioner bus: raw pins and snapshot acknowledge in, conditioned
// button/switch state and confirm strobe out.
interface btn_sw_conditioner_if #(
   parameter int unsigned SW_WIDTH = 16
);
   logic                btn_raw;
   logic [SW_WIDTH-1:0] sw_raw;
   logic                snap_ack;
   logic                confirm_pulse;
   logic                btn_level;
   logic [SW_WIDTH-1:0] sw_sync;
   logic [SW_WIDTH-1:0] sw_snapshot;
   logic                snap_valid;
   logic [7:0]          press_count;

   // Board / consumer side
   modport master (
      output btn_raw, sw_raw, snap_ack,
      input  confirm_pulse, btn_level, sw_sync, sw_snapshot, snap_valid, press_count
   );

   // Conditioner side
   modport slave (
      input  btn_raw, sw_raw, snap_ack,
      output confirm_pulse, btn_level, sw_sync, sw_snapshot, snap_valid, press_count
   );
endinterface

// File: rtl/btn_sw_conditioner.sv
// Synchronises the confirm button and slide switches, debounces the button and
// emits one confirm pulse plus a switch snapshot per accepted press.
module btn_sw_conditioner #(
   parameter int unsigned SW_WIDTH        = 16,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input logic                  clock,
   input logic                  reset,
   btn_sw_conditioner_if.slave  bus
);
   localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned SYNC_W = SW_WIDTH + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_WAIT = 2'd1,
      PRESSED    = 2'd2,
      REL_WAIT   = 2'd3
   } state_t;

   logic [SYNC_W-1:0]   sync_q [SYNC_STAGES];
   logic                btn_s;
   logic [SW_WIDTH-1:0] sw_s;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                accept_c;

   logic                pulse_q, pulse_d;
   logic                level_q, level_d;
   logic [SW_WIDTH-1:0] snap_q, snap_d;
   logic                valid_q, valid_d;
   logic [7:0]          count_q, count_d;

   // Button and switches share one synchroniser chain; button is the MSB
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= {bus.btn_raw, bus.sw_raw};
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign btn_s = sync_q[SYNC_STAGES-1][SW_WIDTH];
   assign sw_s  = sync_q[SYNC_STAGES-1][SW_WIDTH-1:0];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Debounce: a level change is accepted only after DEBOUNCE_CYCLES stable samples
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      accept_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (btn_s) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = PRESSED;
               accept_c = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (!btn_s) begin
               state_d = REL_WAIT;
               cnt_d   = '0;
            end
         end
         REL_WAIT: begin
            if (btn_s) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Capture wins over a coincident acknowledge
   always_comb begin
      pulse_d = accept_c;
      level_d = (state_d == PRESSED) || (state_d == REL_WAIT);
      snap_d  = snap_q;
      valid_d = valid_q;
      count_d = count_q;
      if (accept_c) begin
         snap_d  = sw_s;
         valid_d = 1'b1;
         count_d = count_q + 8'd1;
      end else if (bus.snap_ack) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pulse_q <= 1'b0;
         level_q <= 1'b0;
         snap_q  <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
      end else begin
         pulse_q <= pulse_d;
         level_q <= level_d;
         snap_q  <= snap_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   assign bus.confirm_pulse = pulse_q;
   assign bus.btn_level     = level_q;
   assign bus.sw_sync       = sw_s;
   assign bus.sw_snapshot   = snap_q;
   assign bus.snap_valid    = valid_q;
   assign bus.press_count   = count_q;
endmodule

// File: tb/tb_btn_sw_conditioner.sv
// Bench for btn_sw_conditioner: run-length reference model feeds a scoreboard of
// expected captures; a negedge monitor checks every cycle and every pulse.
module tb_btn_sw_conditioner;
   localparam int unsigned SW = 16;
   localparam int unsigned SS = 2;
   localparam int unsigned DB = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   btn_sw_conditioner_if #(.SW_WIDTH(SW)) bus ();

   btn_sw_conditioner #(
      .SW_WIDTH(SW), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int n_vec  = 0;
   int n_bad  = 0;
   int pulses = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the debounced level flips once the synchronised button has
   // disagreed with it on DB+1 consecutive clock edges.
   typedef struct packed {
      logic [SW-1:0] snap;
      logic [7:0]    count;
   } exp_t;

   exp_t          exp_q[$];
   logic [SW:0]   m_sync [SS];
   logic          m_level;
   int            m_run;
   logic          m_pulse;
   logic [SW-1:0] m_snap;
   logic          m_valid;
   logic [7:0]    m_count;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(SS); i++) m_sync[i] = '0;
         m_level = 1'b0; m_run = 0; m_pulse = 1'b0;
         m_snap = '0; m_valid = 1'b0; m_count = 8'd0;
         exp_q.delete();
      end else begin
         logic [SW:0] s;
         s = m_sync[SS-1];
         m_pulse = 1'b0;
         if (s[SW] != m_level) m_run++;
         else m_run = 0;
         if (m_run == int'(DB) + 1) begin
            m_level = ~m_level;
            m_run   = 0;
            if (m_level) begin
               m_pulse = 1'b1;
               m_count = m_count + 8'd1;
               m_snap  = s[SW-1:0];
               m_valid = 1'b1;
               exp_q.push_back('{snap: s[SW-1:0], count: m_count});
            end
         end
         if (!m_pulse && bus.snap_ack) m_valid = 1'b0;
         for (int i = int'(SS) - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
         m_sync[0] = {bus.btn_raw, bus.sw_raw};
      end
   end

   // Monitor: per-cycle state compare and scoreboard pop on every pulse
   always @(negedge clock) begin
      if (reset) begin
         chk("pulse", 32'(bus.confirm_pulse), 32'(m_pulse));
         chk("level", 32'(bus.btn_level), 32'(m_level));
         chk("sw_sync", 32'(bus.sw_sync), 32'(m_sync[SS-1][SW-1:0]));
         chk("snap_valid", 32'(bus.snap_valid), 32'(m_valid));
         chk("press_count", 32'(bus.press_count), 32'(m_count));
         chk("sw_snapshot", 32'(bus.sw_snapshot), 32'(m_snap));
         if (bus.confirm_pulse) begin
            pulses++;
            chk("sb_depth", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() != 0) begin
               exp_t e;
               e = exp_q.pop_front();
               chk("sb_snapshot", 32'(bus.sw_snapshot), 32'(e.snap));
               chk("sb_count", 32'(bus.press_count), 32'(e.count));
            end
         end
      end
   end

   task automatic wait_pulse(output int k);
      k = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (bus.confirm_pulse) begin
            k = i;
            break;
         end
      end
   endtask

   task automatic wait_fall(output int k);
      k = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (!bus.btn_level) begin
            k = i;
            break;
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pulse"}, 32'(bus.confirm_pulse), 32'd0);
      chk({tag, "_level"}, 32'(bus.btn_level), 32'd0);
      chk({tag, "_sw_sync"}, 32'(bus.sw_sync), 32'd0);
      chk({tag, "_snapshot"}, 32'(bus.sw_snapshot), 32'd0);
      chk({tag, "_valid"}, 32'(bus.snap_valid), 32'd0);
      chk({tag, "_count"}, 32'(bus.press_count), 32'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      int p0;
      logic [7:0] c0;

      bus.btn_raw  = 1'b0;
      bus.sw_raw   = '0;
      bus.snap_ack = 1'b0;
      repeat (3) @(negedge clock);
      chk_all_zero("reset");
      #2 reset = 1'b1;
      repeat (3) @(negedge clock);

      // Clean press: pulse follows edge 6 counted from the first edge seeing btn_raw=1
      bus.sw_raw  = 16'hA5C3;
      bus.btn_raw = 1'b1;
      wait_pulse(k);
      chk("t1_latency", 32'(k), 32'd6);
      chk("t1_snapshot", 32'(bus.sw_snapshot), 32'hA5C3);
      chk("t1_valid", 32'(bus.snap_valid), 32'd1);
      chk("t1_count", 32'(bus.press_count), 32'd1);
      bus.sw_raw = 16'h1234;
      repeat (12) @(negedge clock);
      chk("t1_hold_snapshot", 32'(bus.sw_snapshot), 32'hA5C3);
      bus.btn_raw = 1'b0;
      repeat (10) @(negedge clock);

      // Short glitch is rejected
      bus.btn_raw = 1'b1;
      repeat (3) @(negedge clock);
      bus.btn_raw = 1'b0;
      repeat (10) @(negedge clock);
      chk("t2_count", 32'(bus.press_count), 32'd1);
      chk("t2_pulses", 32'(pulses), 32'd1);

      // Release bounces do not create a second pulse
      bus.btn_raw = 1'b1;
      wait_pulse(k);
      chk("t3_latency", 32'(k), 32'd6);
      repeat (4) @(negedge clock);
      bus.btn_raw = 1'b0; repeat (2) @(negedge clock);
      bus.btn_raw = 1'b1; repeat (2) @(negedge clock);
      bus.btn_raw = 1'b0; repeat (2) @(negedge clock);
      bus.btn_raw = 1'b1; repeat (2) @(negedge clock);
      bus.btn_raw = 1'b0;
      wait_fall(k);
      chk("t3_release_latency", 32'(k), 32'd6);
      chk("t3_pulses", 32'(pulses), 32'd2);
      chk("t3_count", 32'(bus.press_count), 32'd2);
      repeat (4) @(negedge clock);

      // Acknowledge coinciding with a capture: capture wins
      bus.sw_raw  = 16'h0F0F;
      bus.btn_raw = 1'b1;
      repeat (6) @(negedge clock);
      bus.snap_ack = 1'b1;
      @(negedge clock);
      chk("t4_pulse", 32'(bus.confirm_pulse), 32'd1);
      chk("t4_valid", 32'(bus.snap_valid), 32'd1);
      chk("t4_snapshot", 32'(bus.sw_snapshot), 32'h0F0F);
      @(negedge clock);
      chk("t4_ack_clear", 32'(bus.snap_valid), 32'd0);
      bus.snap_ack = 1'b0;
      bus.btn_raw  = 1'b0;
      repeat (10) @(negedge clock);

      // Reset mid-debounce with the button held
      bus.btn_raw = 1'b1;
      repeat (3) @(negedge clock);
      #2 reset = 1'b0;
      #1 chk_all_zero("t5_reset");
      repeat (2) @(negedge clock);
      #2 reset = 1'b1;
      wait_pulse(k);
      chk("t5_latency", 32'(k), 32'd6);
      chk("t5_count", 32'(bus.press_count), 32'd1);
      bus.btn_raw = 1'b0;
      repeat (10) @(negedge clock);

      // 256 clean presses with random switches and acknowledges
      p0 = pulses;
      c0 = bus.press_count;
      for (int n = 0; n < 256; n++) begin
         bus.sw_raw   = SW'($urandom);
         bus.snap_ack = 1'($urandom_range(0, 1));
         bus.btn_raw  = 1'b1;
         repeat (8 + $urandom_range(0, 3)) @(negedge clock);
         bus.snap_ack = 1'($urandom_range(0, 1));
         bus.btn_raw  = 1'b0;
         repeat (8 + $urandom_range(0, 3)) @(negedge clock);
      end
      chk("t6_pulses", 32'(pulses - p0), 32'd256);
      chk("t6_count_wrap", 32'(bus.press_count), 32'(c0));

      // Random bouncy button with random run lengths around the debounce window
      for (int n = 0; n < 400; n++) begin
         bus.btn_raw  = 1'($urandom_range(0, 1));
         bus.sw_raw   = SW'($urandom);
         bus.snap_ack = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 9)) @(negedge clock);
      end
      bus.btn_raw  = 1'b0;
      bus.snap_ack = 1'b0;
      repeat (12) @(negedge clock);
      chk("sb_leftover", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
